scr1_tb_ahb_ram: RTL and testbench
==================================

Name: scr1_tb_ahb_ram

Overview:
- Synthesizable AHB-Lite slave RAM model with programmable wait-state injection.
- Sits directly downstream of the SCR1 AHB top in the testbench, on either the imem port or the dmem port (one instance per port).
- Serves single transfers, applies byte-lane writes, and returns two-cycle ERROR responses for illegal accesses.
- Its wait-state modes stress the core's AHB bridges with fixed and pseudo-random stalls.

Parameters:
- MEM_POWER_SIZE, 16, log2 of RAM size in bytes. RAM is mapped at address 0 up to 2**MEM_POWER_SIZE-1.
- LFSR_SEED, 16'hACE1, reset value of the stall LFSR. Must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall_mode  in  2  0=no stall, 1=fixed stall_cnt, 2=random (lfsr[3:0] & stall_cnt), 3=reserved, treated as 0
- stall_cnt  in  4  wait-state count (mode 1) or mask (mode 2)
- htrans  in  2  AHB transfer type; only NONSEQ (2'b10) is acted on, all others are idle
- hsize  in  3  0=byte, 1=half, 2=word
- haddr  in  32  address-phase address
- hwrite  in  1  1=write
- hwdata  in  32  data-phase write data
- hready  out  1  transfer done / slave ready
- hrdata  out  32  read data, full aligned word
- hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, any time including mid-wait):
  - state=IDLE, hready=1, hresp=0, hrdata=0, lfsr=LFSR_SEED.
  - RAM contents are not cleared.
  - An in-flight write is dropped.
- Acceptance: a transfer is accepted on a rising clk edge where htrans==NONSEQ and hready==1. On acceptance:
  - haddr, hsize and hwrite are registered (addr_q, size_q, write_q).
  - lfsr advances one step. Taps are 16,14,13,11 (Fibonacci) and the shift is left.
  - A wait counter is loaded: 0 in mode 0/3, stall_cnt in mode 1, lfsr_next[3:0] & stall_cnt in mode 2.
  - stall_mode and stall_cnt are sampled only here; changes during a data phase are ignored.
- Error check, done at acceptance. Any of the following makes the transfer illegal:
  - hsize > 2
  - hsize==1 with haddr[0]==1
  - hsize==2 with haddr[1:0]!=0
  - haddr[31:MEM_POWER_SIZE] != 0
- FSM states are IDLE, WAIT, DATA, ERR1, ERR2.
- Transitions on acceptance (from IDLE, DATA-completing or ERR2):
  - Illegal transfer -> ERR1.
  - Legal, counter>0 -> WAIT.
  - Legal, counter==0 -> DATA.
- IDLE: hready=1, hresp=0.
- WAIT: hready=0, hresp=0, counter decrements each cycle. When counter reaches 1, the next state is DATA.
- DATA: hready=1, hresp=0; this is the completion cycle.
  - Read: hrdata = RAM word at addr_q[MEM_POWER_SIZE-1:2]; hrdata=0 in all other states.
  - Write: at this clock edge hwdata lanes are written. Lanes are selected by size_q/addr_q[1:0]: byte -> 1 lane, half -> lanes {addr[1],0}+{0,1}, word -> 4 lanes.
  - Next state: a back-to-back accepted transfer follows the acceptance rules; otherwise IDLE.
- ERR1: hready=0, hresp=1. Next state is always ERR2.
- ERR2: hready=1, hresp=1. Next state follows acceptance rules or IDLE. An illegal write never modifies the RAM.
- Latency: zero-wait read data appears in the cycle after the address phase. Each wait state adds exactly 1 cycle.
- Pipelining: write-then-read of the same word back to back returns the newly written data, because the write commits on the DATA edge and the read completes one or more cycles later.
- Simultaneous events: rst overrides everything. Acceptance in DATA/ERR2 overlaps with completion of the previous transfer, as AHB pipelining requires.

Decomposition:
- Package scr1_tb_ahb_ram_pkg:
  - state enum (IDLE, WAIT, DATA, ERR1, ERR2)
  - stall mode enum
  - function computing the 4-bit byte-enable from size/addr
  - function computing the illegal flag
- HTRANS/HSIZE/HRESP encodings come from the existing SCR1 AHB header.
- One sub-module: scr1_tb_lfsr16 (clk, rst, seed, step, value).

Test Plan:
- Mode 0: write word 0xDEADBEEF @0x100, then read @0x100 -> hready never low, hrdata=0xDEADBEEF in the cycle after the read address phase, hresp=0.
- Mode 1, stall_cnt=3: read @0x104 -> hready low for exactly 3 cycles, then high with data. Changing stall_cnt to 0 mid-wait leaves the total wait at 3.
- Byte/half lanes: after word 0x00000000 @0x200, write byte 0xAA @0x203 and half 0x5566 @0x200, then read -> 0xAA005566.
- Errors: word read @0x202, then write @0x0001_0000 with MEM_POWER_SIZE=16 -> each gives hready=0/hresp=1, then hready=1/hresp=1; RAM word at 0x0 is unchanged.
- Mode 2, stall_cnt=4'hF, 8 back-to-back reads from reset -> wait counts equal the first 8 LFSR-next low nibbles computed from seed 0xACE1 by the reference model.
- rst asserted during WAIT of a write -> hready=1, hresp=0 immediately; the write is not committed; the next transfer after reset completes normally.

Source files
------------

// File: rtl/scr1_tb_ahb_ram_pkg.sv
// Shared types, AHB encodings and helper functions for the testbench AHB RAM.
package scr1_tb_ahb_ram_pkg;

  // AHB-Lite encodings used by the SCR1 AHB bridges
  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] SCR1_HSIZE_8B  = 3'd0;
  localparam logic [2:0] SCR1_HSIZE_16B = 3'd1;
  localparam logic [2:0] SCR1_HSIZE_32B = 3'd2;

  localparam logic SCR1_HRESP_OKAY  = 1'b0;
  localparam logic SCR1_HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } ram_state_e;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_FIXED  = 2'd1,
    STALL_RANDOM = 2'd2,
    STALL_RSVD   = 2'd3
  } stall_mode_e;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Random wait count: low nibble of the advanced LFSR masked by stall_cnt
  function automatic logic [3:0] random_wait(input logic [15:0] cur, input logic [3:0] mask);
    logic [15:0] nxt;
    nxt = lfsr16_next(cur);
    return nxt[3:0] & mask;
  endfunction

  // Byte lanes touched by a transfer of the given size at the given word offset
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SCR1_HSIZE_8B:  be = 4'b0001 << addr_lo;
      SCR1_HSIZE_16B: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SCR1_HSIZE_32B: be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  // Unsupported size, misalignment, or an address beyond the RAM window
  function automatic logic is_illegal(input logic [2:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned mem_power);
    logic bad_align;
    case (size)
      SCR1_HSIZE_8B:  bad_align = 1'b0;
      SCR1_HSIZE_16B: bad_align = addr[0];
      SCR1_HSIZE_32B: bad_align = |addr[1:0];
      default:        bad_align = 1'b1;
    endcase
    return bad_align || ((addr >> mem_power) != 32'd0);
  endfunction

endpackage

// File: rtl/scr1_tb_lfsr16.sv
// 16-bit stall LFSR; advances one step whenever step is high.
module scr1_tb_lfsr16
  import scr1_tb_ahb_ram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  // LFSR register, reloaded with the seed on reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr16_next(value);
    end
  end

endmodule

// File: rtl/scr1_tb_ahb_ram.sv
// AHB-Lite slave RAM with programmable wait-state injection for the SCR1 testbench.
module scr1_tb_ahb_ram
  import scr1_tb_ahb_ram_pkg::*;
#(
  parameter int          MEM_POWER_SIZE = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall_mode,
  input  logic [3:0]  stall_cnt,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int WORDS = 2 ** (MEM_POWER_SIZE - 2);

  logic [31:0] mem [0:WORDS-1];

  ram_state_e                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [3:0]                wait_load;
  logic [MEM_POWER_SIZE-1:0] addr_q;
  logic [2:0]                size_q;
  logic                      write_q;
  logic                      accept;
  logic                      illegal;
  logic [15:0]               lfsr_value;
  logic [3:0]                be_q;
  logic [MEM_POWER_SIZE-3:0] word_idx;

  // hready is a pure function of state, so acceptance is derived from state directly
  assign accept   = (htrans == SCR1_HTRANS_NONSEQ) &&
                    (state_q == IDLE || state_q == DATA || state_q == ERR2);
  assign illegal  = is_illegal(hsize, haddr, MEM_POWER_SIZE);
  assign be_q     = byte_en(size_q, addr_q[1:0]);
  assign word_idx = addr_q[MEM_POWER_SIZE-1:2];

  scr1_tb_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .step  (accept),
    .value (lfsr_value)
  );

  // Wait count for the transfer being accepted, from the stall mode sampled now
  always_comb begin
    case (stall_mode_e'(stall_mode))
      STALL_FIXED:  wait_load = stall_cnt;
      STALL_RANDOM: wait_load = random_wait(lfsr_value, stall_cnt);
      default:      wait_load = 4'd0;
    endcase
  end

  // Next-state, wait counter and bus outputs
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hready  = 1'b1;
    hresp   = SCR1_HRESP_OKAY;
    hrdata  = 32'd0;
    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        hready = 1'b0;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DATA;
      end
      DATA: begin
        if (!write_q) hrdata = mem[word_idx];
        state_d = IDLE;
      end
      ERR1: begin
        hready  = 1'b0;
        hresp   = SCR1_HRESP_ERROR;
        state_d = ERR2;
      end
      ERR2: begin
        hresp   = SCR1_HRESP_ERROR;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new address phase overlaps completion of the previous transfer
    if (accept) begin
      cnt_d = wait_load;
      if (illegal)                state_d = ERR1;
      else if (wait_load != 4'd0) state_d = WAIT;
      else                        state_d = DATA;
    end
  end

  // State, wait counter and address-phase capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= haddr[MEM_POWER_SIZE-1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  // Byte-lane write commit on the completion edge of a legal write
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; contents must survive a reset and it maps to plain memory.
    if (state_q == DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_scr1_tb_ahb_ram.sv
// Self-checking bench for scr1_tb_ahb_ram: scoreboard of expected responses
// filled at issue time, drained by an independent bus monitor.
module tb_scr1_tb_ahb_ram;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_mode;
  logic [3:0]  stall_cnt;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;

  scr1_tb_ahb_ram #(.MEM_POWER_SIZE(16), .LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_mode (stall_mode),
    .stall_cnt  (stall_cnt),
    .htrans     (htrans),
    .hsize      (hsize),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .hwdata     (hwdata),
    .hready     (hready),
    .hrdata     (hrdata),
    .hresp      (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_write;
    bit          err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_mem [int];
  logic [15:0] model_lfsr;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_read(input int addr);
    logic [31:0] r;
    int base;
    base = addr - (addr % 4);
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = model_mem.exists(base + i) ? model_mem[base + i] : 8'hxx;
    return r;
  endfunction

  // ---------------- monitor ----------------
  bit in_dp;
  int mon_waits;
  bit wait_hresp;
  bit wait_rdata_nz;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        if (!hready) begin
          mon_waits++;
          wait_hresp    = wait_hresp | hresp;
          wait_rdata_nz = wait_rdata_nz | (hrdata != 32'd0);
          if (mon_waits > 40) begin
            checks++;
            errors++;
            $display("FAIL data_phase_timeout: waits %0d, limit 40", mon_waits);
            in_dp = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end
        end else begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got a completion, expected none");
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_waits"}, mon_waits, e.waits);
            check({e.name, "_hresp"}, {31'd0, hresp}, {31'd0, e.err});
            check({e.name, "_wait_hresp"}, {31'd0, wait_hresp}, {31'd0, e.err});
            check({e.name, "_wait_hrdata_zero"}, {31'd0, wait_rdata_nz}, 32'd0);
            if (!e.is_write && !e.err) check({e.name, "_hrdata"}, hrdata, e.rdata);
          end
          in_dp = 1'b0;
        end
      end
      if (htrans == 2'b10 && hready) begin
        in_dp         = 1'b1;
        mon_waits     = 0;
        wait_hresp    = 1'b0;
        wait_rdata_nz = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input string name, input bit w, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit commit = 1'b1);
    exp_t e;
    bit   rdy;
    int   n;
    e.name     = name;
    e.is_write = w;
    e.rdata    = 32'd0;
    e.err      = (size > 3'd2) || ((addr % (32'd1 << size)) != 0) || (addr >= 32'h1_0000);
    model_lfsr = {model_lfsr[14:0], ^(model_lfsr & 16'hB400)};
    case (stall_mode)
      2'd1:    e.waits = int'(stall_cnt);
      2'd2:    e.waits = int'(model_lfsr[3:0] & stall_cnt);
      default: e.waits = 0;
    endcase
    if (e.err) begin
      e.waits = 1;
    end else if (w) begin
      if (commit)
        for (int i = 0; i < (1 << size); i++)
          model_mem[int'(addr) + i] = wdata[8*((int'(addr) + i) % 4) +: 8];
    end else begin
      e.rdata = model_read(int'(addr));
    end
    exp_q.push_back(e);
    htrans = 2'b10;
    hwrite = w;
    hsize  = size;
    haddr  = addr;
    n = 0;
    do begin
      @(negedge clk);
      rdy = hready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: hready %b after %0d cycles, expected 1", name, rdy, n);
    end
    #1;
    htrans = 2'b00;
    hwdata = wdata;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_dp) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || in_dp) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_lfsr = SEED;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    stall_mode = 2'd0;
    stall_cnt  = 4'd0;
    htrans     = 2'b00;
    hsize      = 3'd0;
    haddr      = 32'd0;
    hwrite     = 1'b0;
    hwdata     = 32'd0;
    model_lfsr = SEED;
    #2;
    check("reset_hready", {31'd0, hready}, 32'd1);
    check("reset_hresp",  {31'd0, hresp},  32'd0);
    check("reset_hrdata", hrdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Mode 0: zero-wait write then read, plus seed words for later tests
    issue("m0_wr",   1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    issue("m0_rd",   1'b0, 3'd2, 32'h100, 32'h0);
    issue("init104", 1'b1, 3'd2, 32'h104, 32'h01020304);
    issue("init000", 1'b1, 3'd2, 32'h000, 32'h11223344);
    issue("init180", 1'b1, 3'd2, 32'h180, 32'hCAFEF00D);
    drain();

    // Mode 1: three fixed waits; changing stall_cnt mid-wait has no effect
    stall_mode = 2'd1;
    stall_cnt  = 4'd3;
    issue("m1_rd", 1'b0, 3'd2, 32'h104, 32'h0);
    stall_cnt = 4'd0;
    drain();
    stall_mode = 2'd0;

    // Byte and halfword lanes
    issue("ln_w0", 1'b1, 3'd2, 32'h200, 32'h00000000);
    issue("ln_b3", 1'b1, 3'd0, 32'h203, 32'hAA000000);
    issue("ln_h0", 1'b1, 3'd1, 32'h200, 32'h00005566);
    issue("ln_rd", 1'b0, 3'd2, 32'h200, 32'h0);
    drain();
    check("lanes_model", model_read(32'h200), 32'hAAAA_AAAA & 32'hAA00_0000 | 32'h0000_5566);

    // Illegal transfers: misaligned word read, out-of-range write
    issue("err_rd",  1'b0, 3'd2, 32'h202,    32'h0);
    issue("err_wr",  1'b1, 3'd2, 32'h1_0000, 32'h99999999);
    issue("err_chk", 1'b0, 3'd2, 32'h000,    32'h0);
    issue("err_sz",  1'b0, 3'd3, 32'h000,    32'h0);
    drain();

    // Mode 2 from reset: eight back-to-back reads with LFSR-driven waits
    do_reset();
    stall_mode = 2'd2;
    stall_cnt  = 4'hF;
    for (int i = 0; i < 8; i++) issue($sformatf("m2_rd%0d", i), 1'b0, 3'd2, 32'h100, 32'h0);
    drain();

    // Reset in the middle of a stalled write drops the write
    stall_mode = 2'd1;
    stall_cnt  = 4'd5;
    issue("rst_wr", 1'b1, 3'd2, 32'h180, 32'h12345678, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_hready", {31'd0, hready}, 32'd1);
    check("rst_mid_hresp",  {31'd0, hresp},  32'd0);
    exp_q.delete();
    model_lfsr = SEED;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_mode = 2'd0;
    issue("rst_rd", 1'b0, 3'd2, 32'h180, 32'h0);
    drain();

    // Randomized traffic over an initialised window
    for (int i = 0; i < 64; i++)
      issue("rnd_init", 1'b1, 3'd2, 32'h300 + 32'(4 * i), $urandom);
    drain();
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      stall_mode = 2'($urandom_range(0, 3));
      stall_cnt  = 4'($urandom_range(0, 15));
      sz         = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a          = 32'h300 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = a | 32'h0002_0000;
      issue($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, a, $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
